aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Sequential AES-128 key expansion controller that produces the 11 round keys, RK0 to RK10, from a 128-bit cipher key. It sits directly upstream of the 32-bit word SubBytes stage. For each round it sends a RotWord-ed word to that stage, waits for the substituted result, applies Rcon, and derives the next four key words. Round keys stream out one per round to the round-key store or datapath.

## Interface
- TIMEOUT, default 255: maximum cycles spent waiting for sub_done before the block aborts.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to expand key; ignored while busy=1.
- key  in  128  cipher key, sampled only when start is accepted; word w0 = key[127:96].
- sub_word  out  32  word sent to the SubBytes stage; valid while sub_req=1.
- sub_req  out  1  one-cycle pulse; connects to the SubBytes stage ready input, which has its encrypt input tied to 1.
- sub_result  in  32  substituted word from the SubBytes stage.
- sub_done  in  1  SubBytes stage done pulse.
- rk  out  128  round key {w0,w1,w2,w3}; valid while rk_valid=1.
- rk_valid  out  1  one-cycle pulse per round key.
- rk_index  out  4  round number 0..10 for rk.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse after RK10 has been emitted.
- error  out  1  sticky timeout flag; cleared by reset or by the next accepted start.

## Operation
- Registers: w0..w3 (32b each), rcon (8b), round (4b), wait timer (8b minimum, saturating), state.
- IDLE: when start=1, load w0..w3 from key, set rcon=8'h01, round=0, clear error, and go to EMIT.
- EMIT: rk_valid=1, rk={w0,w1,w2,w3}, rk_index=round.
  - If round==10, go to FINISH.
  - Otherwise go to SUB_REQ.
- SUB_REQ: sub_req=1, sub_word={w3[23:0],w3[31:24]} (RotWord). Clear the timer and go to SUB_WAIT.
- SUB_WAIT, on sub_done=1:
  - t = sub_result ^ {rcon,24'h0}.
  - Compute w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon = xtime(rcon): {rcon[6:0],1'b0}, XOR 8'h1B if rcon[7] was set.
  - round=round+1, then go to EMIT.
- SUB_WAIT timeout: while sub_done=0, increment the timer. When it reaches TIMEOUT, set error=1 and go to IDLE; no done pulse and no further rk_valid.
- FINISH: done=1 for one cycle, then go to IDLE.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- sub_done outside SUB_WAIT is ignored; it does not advance state.
- start while busy is ignored; the current expansion continues undisturbed.
- All arithmetic is XOR only; there are no carries and no width growth.

## Timing
- Reset values: sub_req=0, rk_valid=0, done=0, busy=0, error=0, rk_index=0, rk=0, sub_word=0, state=IDLE. Reset mid-expansion aborts immediately with these values; a late sub_done afterwards is ignored.
- All outputs are registered (Moore).
  - busy=1 in every state except IDLE.
  - rk_valid, sub_req and done are high for exactly one cycle per occurrence.
- Start accepted at edge k: busy=1 and rk_valid for RK0 are both high in cycle k+1.
- Per round: EMIT (1 cycle) + SUB_REQ (1 cycle) + W cycles in SUB_WAIT, where the cycle in which sub_done is sampled counts in W. The next EMIT follows immediately.
- Total from start accept to done pulse: 11 EMIT + 10×(1+W) + 1 FINISH cycles. For a fixed W this is 22+10W.
- The block never depends on a fixed SubBytes latency; only the sub_done handshake is used.
- Exactly one sub_req is outstanding at a time. The next sub_req is never issued before the sub_done for the current request.
- Back-to-back expansion: start may be accepted in the cycle after done, when state=IDLE.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, with a behavioural SubBytes model of latency 3:
  - RK0 equals the key, rk_index=0.
  - First sub_word=cf4f3c09; the model returns 8a84eb01.
  - RK1=a0fafe1788542cb123a339392a6c7605.
  - RK10=d014f9a8c9ee2589e13f0cc8b6630ca6, then done pulses once and busy falls.
- Same key with model latencies of 1 and 7 cycles: identical rk sequence; total cycles equal 22+10W; exactly 11 rk_valid pulses and 10 sub_req pulses.
- Spurious sub_done during EMIT, and start pulsed mid-expansion: no state change, RK values unchanged, only one expansion completes.
- Model withholds sub_done in round 4: after TIMEOUT cycles, error=1 and busy=0, with no done pulse. A new start clears error and completes normally.
- Reset asserted during round 5 SUB_WAIT, followed by a late sub_done: all outputs at reset values and no rk_valid. A subsequent start with key 000102030405060708090a0b0c0d0e0f yields RK10=13111d7fe3944a17f307a78b4d2b30c5.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion controller: streams RK0..RK10 one per round, using an
// external 32-bit SubBytes stage through a sub_req/sub_done handshake.
module aes_key_schedule #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic [31:0]  sub_word,
    output logic         sub_req,
    input  logic [31:0]  sub_result,
    input  logic         sub_done,
    output logic [127:0] rk,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [2:0]   state_o
);

    // Handshake: sub_req is a one-cycle request carrying sub_word; the stage answers
    // with a one-cycle sub_done carrying sub_result. Only one request is in flight,
    // and sub_done is honoured only while waiting for it.

    localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EMIT     = 3'd1,
        S_SUB_REQ  = 3'd2,
        S_SUB_WAIT = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    state_t         state_q;
    logic [31:0]    w0_q, w1_q, w2_q, w3_q;
    logic [7:0]     rcon_q;
    logic [3:0]     round_q;
    logic [TW-1:0]  timer_q;
    logic [31:0]    sub_word_q;
    logic           sub_req_q;
    logic [127:0]   rk_q;
    logic           rk_valid_q;
    logic [3:0]     rk_index_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;

    logic [31:0]    t_w;
    logic [31:0]    w0_d, w1_d, w2_d, w3_d;
    logic [7:0]     rcon_d;

    always_comb begin
        t_w    = sub_result ^ {rcon_q, 24'h0};
        w0_d   = w0_q ^ t_w;
        w1_d   = w1_q ^ w0_d;
        w2_d   = w2_q ^ w1_d;
        w3_d   = w3_q ^ w2_d;
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
    end

    // Outputs are registered for the state being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            w0_q       <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            w3_q       <= '0;
            rcon_q     <= '0;
            round_q    <= '0;
            timer_q    <= '0;
            sub_word_q <= '0;
            sub_req_q  <= 1'b0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_index_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w0_q       <= key[127:96];
                        w1_q       <= key[95:64];
                        w2_q       <= key[63:32];
                        w3_q       <= key[31:0];
                        rcon_q     <= 8'h01;
                        round_q    <= 4'd0;
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        rk_q       <= key;
                        rk_index_q <= 4'd0;
                        rk_valid_q <= 1'b1;
                        state_q    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    rk_valid_q <= 1'b0;
                    if (round_q == 4'd10) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        sub_word_q <= {w3_q[23:0], w3_q[31:24]};
                        sub_req_q  <= 1'b1;
                        state_q    <= S_SUB_REQ;
                    end
                end
                S_SUB_REQ: begin
                    sub_req_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= S_SUB_WAIT;
                end
                S_SUB_WAIT: begin
                    if (sub_done) begin
                        w0_q       <= w0_d;
                        w1_q       <= w1_d;
                        w2_q       <= w2_d;
                        w3_q       <= w3_d;
                        rcon_q     <= rcon_d;
                        round_q    <= round_q + 4'd1;
                        rk_q       <= {w0_d, w1_d, w2_d, w3_d};
                        rk_index_q <= round_q + 4'd1;
                        rk_valid_q <= 1'b1;
                        state_q    <= S_EMIT;
                    end else if (timer_q >= TLAST) begin
                        // The TIMEOUT-th idle wait cycle aborts; the timer never wraps.
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    sub_req_q  <= 1'b0;
                    rk_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign sub_word = sub_word_q;
    assign sub_req  = sub_req_q;
    assign rk       = rk_q;
    assign rk_valid = rk_valid_q;
    assign rk_index = rk_index_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: behavioural SubBytes stage with programmable latency,
// FIPS-197 round-key table, and directed corner-case sequences.
module tb_aes_key_schedule;

  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset_r = 1'b1;
  logic         start_r = 1'b0;
  logic [127:0] key_r = '0;
  logic [31:0]  sub_word;
  logic         sub_req;
  logic [31:0]  mdl_res = '0;
  logic         mdl_done = 1'b0;
  logic         spur_done = 1'b0;
  logic         sub_done_w;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;
  logic         error;
  logic [2:0]   state_o;

  assign sub_done_w = mdl_done | spur_done;

  aes_key_schedule #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset_r), .start(start_r), .key(key_r),
    .sub_word(sub_word), .sub_req(sub_req), .sub_result(mdl_res), .sub_done(sub_done_w),
    .rk(rk), .rk_valid(rk_valid), .rk_index(rk_index), .busy(busy), .done(done),
    .error(error), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  // GF(2^8) reference for the SubBytes model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes stage model: answers each sub_req mdl_lat cycles later unless told to skip
  int       mdl_lat = 3;
  int       skip_round = 15;
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (sub_req && (int'(rk_index) != skip_round)) begin
        w = sub_word;
        repeat (mdl_lat) @(negedge clk);
        mdl_res  = subw(w);
        mdl_done = 1'b1;
        @(negedge clk);
        mdl_done = 1'b0;
      end
    end
  end

  // monitor: captures every rk and sub_word, counts pulses and cycles
  int           cyc = 0, rk_cnt = 0, sr_cnt = 0, done_cnt = 0, rk0_cyc = 0, done_cyc = 0;
  logic [127:0] cap_rk[256];
  logic [3:0]   cap_idx[256];
  logic [31:0]  cap_sw[256];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rk_valid) begin
      cap_rk[rk_cnt % 256]  <= rk;
      cap_idx[rk_cnt % 256] <= rk_index;
      rk_cnt <= rk_cnt + 1;
      if (rk_index == 4'd0) rk0_cyc <= cyc;
    end
    if (sub_req) begin
      cap_sw[sr_cnt % 256] <= sub_word;
      sr_cnt <= sr_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // scoreboard
  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } vec_t;
  vec_t vecs[11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  // drivers
  task automatic pulse_start(input logic [127:0] k);
    key_r   = k;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: done not seen within 3000 cycles", name);
    end
  endtask

  task automatic wait_sub(input int idx, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (sub_req && int'(rk_index) == idx) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: sub_req for round %0d not seen", name, idx);
    end
  endtask

  task automatic check_table(input int b, input string tag);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("%s_rk%0d", tag, i), cap_rk[(b + i) % 256], vecs[i].rk);
      check($sformatf("%s_idx%0d", tag, i), 128'(cap_idx[(b + i) % 256]), 128'(vecs[i].idx));
    end
  endtask

  // full FIPS expansion at a given SubBytes latency
  task automatic run_fips(input int lat);
    int b_rk, b_sr, b_dn;
    string tag;
    tag = $sformatf("lat%0d", lat);
    mdl_lat = lat;
    b_rk = rk_cnt; b_sr = sr_cnt; b_dn = done_cnt;
    pulse_start(FIPS_KEY);
    check({tag, "_busy_k1"}, 128'(busy), 128'(1));
    check({tag, "_rkvalid_k1"}, 128'(rk_valid), 128'(1));
    check({tag, "_rk0_k1"}, rk, FIPS_KEY);
    wait_done(tag);
    @(negedge clk);
    check({tag, "_busy_fall"}, 128'(busy), 128'(0));
    check({tag, "_done_1cyc"}, 128'(done), 128'(0));
    repeat (3) @(negedge clk);
    check({tag, "_sw0"}, 128'(cap_sw[b_sr % 256]), 128'(32'hcf4f3c09));
    check_table(b_rk, tag);
    check({tag, "_rk_pulses"}, 128'(rk_cnt - b_rk), 128'(11));
    check({tag, "_sr_pulses"}, 128'(sr_cnt - b_sr), 128'(10));
    check({tag, "_done_pulses"}, 128'(done_cnt - b_dn), 128'(1));
    check({tag, "_cycles"}, 128'(done_cyc - rk0_cyc + 1), 128'(22 + 10 * lat));
  endtask

  initial begin
    int b_rk, b_dn, n;
    bit seen;
    vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    // reset state
    repeat (3) @(negedge clk);
    reset_r = 1'b0;
    @(negedge clk);
    check("rst_sub_req", 128'(sub_req), 128'(0));
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_rk_index", 128'(rk_index), 128'(0));
    check("rst_rk", rk, 128'(0));
    check("rst_sub_word", 128'(sub_word), 128'(0));

    // FIPS key at three latencies, back-to-back
    run_fips(3);
    run_fips(1);
    run_fips(7);

    // spurious sub_done in EMIT and start while busy
    mdl_lat = 3;
    repeat (2) @(negedge clk);
    b_rk = rk_cnt; b_dn = done_cnt;
    pulse_start(FIPS_KEY);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (rk_valid && rk_index == 4'd2) seen = 1;
      else @(negedge clk);
    end
    check("spur_emit_seen", 128'(seen), 128'(1));
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    wait_sub(5, "spur");
    @(negedge clk);
    pulse_start(SEQ_KEY);
    wait_done("spur");
    repeat (30) @(negedge clk);
    check_table(b_rk, "spur");
    check("spur_rk_pulses", 128'(rk_cnt - b_rk), 128'(11));
    check("spur_done_pulses", 128'(done_cnt - b_dn), 128'(1));
    check("spur_idle_busy", 128'(busy), 128'(0));

    // timeout in round 4, then recovery
    skip_round = 4;
    b_rk = rk_cnt; b_dn = done_cnt;
    pulse_start(FIPS_KEY);
    wait_sub(4, "tmo");
    n = 0;
    seen = 0;
    for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (error) seen = 1;
    end
    check("tmo_latency", 128'(n), 128'(TIMEOUT + 1));
    check("tmo_error", 128'(error), 128'(1));
    check("tmo_busy", 128'(busy), 128'(0));
    repeat (5) @(negedge clk);
    check("tmo_no_done", 128'(done_cnt - b_dn), 128'(0));
    check("tmo_rk_pulses", 128'(rk_cnt - b_rk), 128'(5));
    check("tmo_error_sticky", 128'(error), 128'(1));
    skip_round = 15;
    b_rk = rk_cnt;
    pulse_start(FIPS_KEY);
    check("tmo_error_clear", 128'(error), 128'(0));
    wait_done("tmo_recover");
    repeat (3) @(negedge clk);
    check("tmo_recover_rk10", cap_rk[(b_rk + 10) % 256], vecs[10].rk);
    check("tmo_recover_error", 128'(error), 128'(0));

    // reset during round 5 SUB_WAIT, late sub_done afterwards
    pulse_start(FIPS_KEY);
    wait_sub(5, "rst_mid");
    @(negedge clk);
    reset_r = 1'b1;
    @(negedge clk);
    reset_r = 1'b0;
    b_rk = rk_cnt;
    check("rstmid_busy", 128'(busy), 128'(0));
    check("rstmid_rk", rk, 128'(0));
    repeat (6) @(negedge clk);
    check("rstmid_no_rk", 128'(rk_cnt - b_rk), 128'(0));
    check("rstmid_rk_valid", 128'(rk_valid), 128'(0));
    check("rstmid_sub_req", 128'(sub_req), 128'(0));
    check("rstmid_rk_index", 128'(rk_index), 128'(0));
    check("rstmid_sub_word", 128'(sub_word), 128'(0));
    check("rstmid_done", 128'(done), 128'(0));
    check("rstmid_error", 128'(error), 128'(0));
    check("rstmid_busy_late", 128'(busy), 128'(0));
    b_rk = rk_cnt;
    pulse_start(SEQ_KEY);
    wait_done("seq_key");
    repeat (3) @(negedge clk);
    check("seq_rk0", cap_rk[b_rk % 256], SEQ_KEY);
    check("seq_rk10", cap_rk[(b_rk + 10) % 256], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("seq_rk_pulses", 128'(rk_cnt - b_rk), 128'(11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
